// File: rtl/m72_pkg.sv
// Shared line geometry for the SDRAM read responder.
// A line is LINE_HW halfwords; the tag is the halfword address above the
// line offset (addr[24:3]).
package m72_pkg;

    localparam int unsigned LINE_HW  = 4;
    localparam int unsigned TAG_W    = 22;
    localparam int unsigned HW_W     = 16;
    localparam int unsigned HW_IDX_W = $clog2(LINE_HW);

    localparam logic [HW_IDX_W-1:0] LAST_HW = HW_IDX_W'(LINE_HW - 1);

    typedef logic [TAG_W-1:0]              tag_t;
    typedef logic [LINE_HW-1:0][HW_W-1:0]  line_t;

endpackage

// File: rtl/resp_line_buf.sv
// Single-line read buffer: four halfwords plus tag and valid bit.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_en/wr_idx/wr_data  halfword write port used while filling
//   set_valid/set_tag   mark the line valid with the given tag
//   inv                 clear valid (wins over set_valid in the same cycle)
//   line_data/valid/tag current contents
module resp_line_buf
    import m72_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [HW_IDX_W-1:0] wr_idx,
    input  logic [HW_W-1:0]     wr_data,
    input  logic                set_valid,
    input  tag_t                set_tag,
    input  logic                inv,
    output line_t               line_data,
    output logic                valid,
    output tag_t                tag
);

    line_t line_q, line_d;
    logic  valid_q, valid_d;
    tag_t  tag_q, tag_d;

    always_comb begin
        line_d  = line_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        if (wr_en) begin
            line_d[wr_idx] = wr_data;
        end
        if (set_valid) begin
            valid_d = 1'b1;
            tag_d   = set_tag;
        end
        if (inv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            line_q  <= line_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign line_data = line_q;
    assign valid     = valid_q;
    assign tag       = tag_q;

endmodule

// File: rtl/sdram_read_responder.sv
// 32-bit read responder in front of a 16-bit memory port, with a one-line
// read cache (CACHE_EN=1) and a one-deep pending request slot.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   sdr_addr/sdr_req     halfword request address and one-cycle strobe
//   sdr_data/sdr_rdy     response dword and one-cycle strobe
//   inv                  one-cycle cache invalidate
//   mem_addr/mem_rd      halfword read address and held read request
//   mem_ack/mem_dout     per-halfword completion and data
module sdram_read_responder
    import m72_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:1] sdr_addr,
    input  logic        sdr_req,
    output logic [31:0] sdr_data,
    output logic        sdr_rdy,
    input  logic        inv,
    output logic [24:1] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t                state_q, state_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [24:1]           mem_addr_q, mem_addr_d;
    logic                  sdr_rdy_q, sdr_rdy_d;
    logic [31:0]           sdr_data_q, sdr_data_d;
    logic [HW_IDX_W-1:0]   k_q, k_d;
    logic                  idx_q, idx_d;
    tag_t                  tag_q, tag_d;
    logic                  pend_q, pend_d;
    logic [24:2]           pend_addr_q, pend_addr_d;
    logic                  inv_fill_q, inv_fill_d;

    logic                  lb_wr_en;
    logic                  lb_set_valid;
    line_t                 lb_line;
    logic                  lb_valid;
    tag_t                  lb_tag;

    logic [24:2]           req_addr;
    tag_t                  req_tag;
    logic                  req_idx;
    logic                  hit;
    logic                  addr_bit1_unused;

    // Requests are dword aligned; halfword bit 1 carries no information.
    assign addr_bit1_unused = sdr_addr[1];

    // A pending request takes priority over a strobe arriving in IDLE.
    assign req_addr = pend_q ? pend_addr_q : sdr_addr[24:2];
    assign req_tag  = req_addr[24:3];
    assign req_idx  = req_addr[2];
    assign hit      = CACHE_EN && lb_valid && (lb_tag == req_tag);

    resp_line_buf u_line (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (lb_wr_en),
        .wr_idx    (k_q),
        .wr_data   (mem_dout),
        .set_valid (lb_set_valid),
        .set_tag   (tag_q),
        .inv       (inv),
        .line_data (lb_line),
        .valid     (lb_valid),
        .tag       (lb_tag)
    );

    always_comb begin
        state_d      = state_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        sdr_rdy_d    = 1'b0;
        sdr_data_d   = sdr_data_q;
        k_d          = k_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        inv_fill_d   = inv_fill_q;
        lb_wr_en     = 1'b0;
        lb_set_valid = 1'b0;

        if (state_q != IDLE && sdr_req) begin
            pend_d      = 1'b1;
            pend_addr_d = sdr_addr[24:2];
        end

        unique case (state_q)
            IDLE: begin
                if (pend_q || sdr_req) begin
                    // Serving the pending slot while a new strobe arrives
                    // leaves the new strobe queued behind it.
                    pend_d = pend_q && sdr_req;
                    if (pend_q && sdr_req) begin
                        pend_addr_d = sdr_addr[24:2];
                    end
                    tag_d = req_tag;
                    idx_d = req_idx;
                    if (hit) begin
                        state_d    = RESP;
                        sdr_rdy_d  = 1'b1;
                        sdr_data_d = req_idx ? {lb_line[3], lb_line[2]}
                                             : {lb_line[1], lb_line[0]};
                    end else begin
                        state_d    = FILL;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {req_tag, {HW_IDX_W{1'b0}}};
                        k_d        = '0;
                        inv_fill_d = 1'b0;
                    end
                end
            end
            FILL: begin
                // An invalidate seen anywhere in the fill keeps the line
                // invalid once the fill lands.
                if (inv) begin
                    inv_fill_d = 1'b1;
                end
                if (mem_ack) begin
                    lb_wr_en = 1'b1;
                    if (k_q == LAST_HW) begin
                        mem_rd_d     = 1'b0;
                        state_d      = RESP;
                        sdr_rdy_d    = 1'b1;
                        lb_set_valid = !inv_fill_q;
                        // The last halfword is still on mem_dout this cycle.
                        sdr_data_d   = idx_q ? {mem_dout, lb_line[2]}
                                             : {lb_line[1], lb_line[0]};
                    end else begin
                        k_d        = k_q + 1'b1;
                        mem_addr_d = {tag_q, k_q + 1'b1};
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            sdr_rdy_q   <= 1'b0;
            sdr_data_q  <= '0;
            k_q         <= '0;
            idx_q       <= 1'b0;
            tag_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            inv_fill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            sdr_rdy_q   <= sdr_rdy_d;
            sdr_data_q  <= sdr_data_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            inv_fill_q  <= inv_fill_d;
        end
    end

    assign sdr_rdy  = sdr_rdy_q;
    assign sdr_data = sdr_data_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_sdram_read_responder.sv
// Bench for sdram_read_responder: directed scenarios followed by a random
// request mix checked against a valid/tag model of the single cached line.
// A second instance with CACHE_EN=0 shares the request inputs.
module tb_sdram_read_responder;

    logic        clk;
    logic        reset;
    logic [24:1] sdr_addr;
    logic        sdr_req;
    logic        inv;

    logic [31:0] sdr_data, sdr_data_n;
    logic        sdr_rdy, sdr_rdy_n;
    logic [24:1] mem_addr, mem_addr_n;
    logic        mem_rd, mem_rd_n;
    logic        mem_ack, mem_ack_n;
    logic [15:0] mem_dout, mem_dout_n;

    int          errors = 0;
    int          checks = 0;
    bit          rand_wait = 0;
    logic [24:1] acks[$];
    int          reads_n = 0;

    sdram_read_responder #(.CACHE_EN(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .sdr_addr (sdr_addr),
        .sdr_req  (sdr_req),
        .sdr_data (sdr_data),
        .sdr_rdy  (sdr_rdy),
        .inv      (inv),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack),
        .mem_dout (mem_dout)
    );

    sdram_read_responder #(.CACHE_EN(1'b0)) dut_nc (
        .clk      (clk),
        .reset    (reset),
        .sdr_addr (sdr_addr),
        .sdr_req  (sdr_req),
        .sdr_data (sdr_data_n),
        .sdr_rdy  (sdr_rdy_n),
        .inv      (inv),
        .mem_addr (mem_addr_n),
        .mem_rd   (mem_rd_n),
        .mem_ack  (mem_ack_n),
        .mem_dout (mem_dout_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of the halfword address.
    function automatic logic [15:0] mem_val(input logic [24:1] a);
        case (a)
            24'h000100: return 16'h1111;
            24'h000101: return 16'h2222;
            24'h000102: return 16'h3333;
            24'h000103: return 16'h4444;
            default:    return a[16:1] ^ {a[24:17], a[8:1]} ^ 16'hA5C3;
        endcase
    endfunction

    function automatic logic [31:0] exp_dw(input logic [24:1] a);
        logic [24:1] lo, hi;
        lo = {a[24:2], 1'b0};
        hi = {a[24:2], 1'b1};
        return {mem_val(hi), mem_val(lo)};
    endfunction

    // Memory: first cycle of a read is an access cycle, then one halfword
    // per cycle (optionally stalled at random).
    initial begin : mem_model
        bit prev;
        prev     = 1'b0;
        mem_ack  = 1'b0;
        mem_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack  = mem_rd && prev && (!rand_wait || $urandom_range(0, 1) == 1);
            mem_dout = mem_ack ? mem_val(mem_addr) : 16'($urandom);
            if (mem_ack) acks.push_back(mem_addr);
            prev = mem_rd;
        end
    end

    initial begin : mem_model_nc
        bit prev;
        prev       = 1'b0;
        mem_ack_n  = 1'b0;
        mem_dout_n = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_n  = mem_rd_n && prev;
            mem_dout_n = mem_ack_n ? mem_val(mem_addr_n) : 16'($urandom);
            if (mem_ack_n) reads_n++;
            prev = mem_rd_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:1] ack_at(input int unsigned i);
        if (i < acks.size()) return acks[i];
        return 'x;
    endfunction

    // One request from IDLE; lat counts cycles from the request cycle to sdr_rdy.
    task automatic do_req(input logic [24:1] a, input bit with_inv, output int lat,
                          output logic [31:0] data, output int nreads, output bit rd_seen);
        tick();
        acks.delete();
        sdr_addr = a;
        sdr_req  = 1'b1;
        inv      = with_inv;
        rd_seen  = 1'b0;
        tick();
        sdr_req  = 1'b0;
        inv      = 1'b0;
        sdr_addr = 24'($urandom);
        lat      = 1;
        while (!sdr_rdy && lat < 200) begin
            if (mem_rd) rd_seen = 1'b1;
            tick();
            lat++;
        end
        check("rdy_seen", sdr_rdy, 1'b1);
        data   = sdr_data;
        nreads = acks.size();
    endtask

    int          lat, nr, cyc, n_rdy;
    logic [31:0] d;
    bit          rs, mv, exp_hit;
    logic [21:0] mtag, tg;
    logic [24:1] a;
    int          rdy_cyc[$];
    logic [31:0] rdy_dat[$];
    logic [21:0] tags[4] = '{22'h000020, 22'h000021, 22'h000040, 22'h3FFFFF};

    initial begin
        reset    = 1'b1;
        sdr_addr = '0;
        sdr_req  = 1'b0;
        inv      = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_sdr_rdy", sdr_rdy, 1'b0);
        check("rst_sdr_data", sdr_data, 32'h0);
        check("rst_mem_addr", mem_addr, 24'h0);
        reset = 1'b0;

        // Cold miss
        do_req(24'h000100, 1'b0, lat, d, nr, rs);
        check("cold_lat", lat, 6);
        check("cold_data", d, 32'h22221111);
        check("cold_nreads", nr, 4);
        for (int unsigned i = 0; i < 4; i++) check("cold_addr", ack_at(i), 24'h000100 + i);
        tick();
        check("cold_rdy_pulse", sdr_rdy, 1'b0);
        check("cold_data_hold", sdr_data, 32'h22221111);

        // Hit on the upper dword
        do_req(24'h000102, 1'b0, lat, d, nr, rs);
        check("hit_lat", lat, 1);
        check("hit_data", d, 32'h44443333);
        check("hit_nreads", nr, 0);
        check("hit_mem_rd", rs, 1'b0);

        // Second request during fill is held and served as a hit
        tick();
        acks.delete();
        rdy_cyc.delete();
        rdy_dat.delete();
        sdr_addr = 24'h000200; sdr_req = 1'b1;
        tick();
        sdr_req = 1'b0;
        tick();
        sdr_addr = 24'h000202; sdr_req = 1'b1;
        tick();
        sdr_req = 1'b0;
        cyc = 3;
        while (cyc <= 20) begin
            if (sdr_rdy) begin
                rdy_cyc.push_back(cyc);
                rdy_dat.push_back(sdr_data);
            end
            tick();
            cyc++;
        end
        check("pend_nrdy", rdy_cyc.size(), 2);
        if (rdy_cyc.size() == 2) begin
            check("pend_cyc0", rdy_cyc[0], 6);
            check("pend_dat0", rdy_dat[0], exp_dw(24'h000200));
            check("pend_cyc1", rdy_cyc[1], 8);
            check("pend_dat1", rdy_dat[1], exp_dw(24'h000202));
        end
        check("pend_nreads", acks.size(), 4);

        // Invalidate during the second ack of a fill
        tick();
        acks.delete();
        sdr_addr = 24'h000300; sdr_req = 1'b1;
        tick();
        sdr_req = 1'b0;
        tick();
        tick();
        inv = 1'b1;
        tick();
        inv = 1'b0;
        cyc = 4;
        while (!sdr_rdy && cyc < 100) begin
            tick();
            cyc++;
        end
        check("invf_lat", cyc, 6);
        check("invf_data", sdr_data, exp_dw(24'h000300));
        do_req(24'h000302, 1'b0, lat, d, nr, rs);
        check("invf_refill_nreads", nr, 4);
        check("invf_refill_lat", lat, 6);
        check("invf_refill_data", d, exp_dw(24'h000302));

        // Invalidate coinciding with a hit: served, then the line is gone
        do_req(24'h000300, 1'b1, lat, d, nr, rs);
        check("invh_lat", lat, 1);
        check("invh_nreads", nr, 0);
        check("invh_data", d, exp_dw(24'h000300));
        do_req(24'h000300, 1'b0, lat, d, nr, rs);
        check("invh_after_nreads", nr, 4);

        // Reset after the second ack of a fill
        tick();
        acks.delete();
        sdr_addr = 24'h000400; sdr_req = 1'b1;
        tick();
        sdr_req = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rstf_mem_rd", mem_rd, 1'b0);
        check("rstf_mem_addr", mem_addr, 24'h0);
        tick();
        tick();
        reset = 1'b0;
        n_rdy = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (sdr_rdy) n_rdy++;
            tick();
        end
        check("rstf_no_rdy", n_rdy, 0);
        do_req(24'h000402, 1'b0, lat, d, nr, rs);
        check("rstf_nreads", nr, 4);
        check("rstf_first_addr", ack_at(0), 24'h000400);
        check("rstf_lat", lat, 6);
        check("rstf_data", d, exp_dw(24'h000402));

        // Top of the address space: no wrap
        do_req(24'hFFFFFE, 1'b0, lat, d, nr, rs);
        check("top_nreads", nr, 4);
        check("top_addr0", ack_at(0), 24'hFFFFFC);
        check("top_addr3", ack_at(3), 24'hFFFFFF);
        check("top_data", d, exp_dw(24'hFFFFFE));

        // Random mix against a valid/tag model, with memory stalls
        rand_wait = 1'b1;
        mv   = 1'b1;
        mtag = 22'h3FFFFF;
        for (int unsigned it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                tick();
                inv = 1'b1;
                tick();
                inv = 1'b0;
                mv  = 1'b0;
            end
            tg      = tags[$urandom_range(0, 3)];
            a       = {tg, 2'($urandom_range(0, 3))};
            exp_hit = mv && (mtag == tg);
            do_req(a, 1'b0, lat, d, nr, rs);
            check("rnd_data", d, exp_dw(a));
            check("rnd_nreads", nr, exp_hit ? 4'd0 : 4'd4);
            if (exp_hit) check("rnd_hit_lat", lat, 1);
            else         check("rnd_fill_base", ack_at(0), {tg, 2'b00});
            mv   = 1'b1;
            mtag = tg;
        end
        rand_wait = 1'b0;

        // CACHE_EN=0: identical requests both fill
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int unsigned rep = 0; rep < 2; rep++) begin
            tick();
            reads_n  = 0;
            sdr_addr = 24'h000500;
            sdr_req  = 1'b1;
            tick();
            sdr_req = 1'b0;
            cyc = 1;
            while (!sdr_rdy_n && cyc < 200) begin
                tick();
                cyc++;
            end
            check("nc_rdy", sdr_rdy_n, 1'b1);
            check("nc_lat", cyc, 6);
            check("nc_data", sdr_data_n, exp_dw(24'h000500));
            check("nc_reads", reads_n, 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_read_responder.md
SDRAM_READ_RESPONDER -- requirements
Module: sdram_read_responder

Interface
REQ-001 Parameter: CACHE_EN, 1, 1 = single-line read cache enabled; 0 = every request is treated as a miss.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sdr_addr  input  24 [24:1]  halfword address of the request; sampled only when sdr_req=1; bit 1 ignored (requests are 32-bit aligned).
REQ-005 sdr_req  input  1  one-cycle request strobe.
REQ-006 sdr_data  output  32  response data; valid in the cycle sdr_rdy=1; holds its value otherwise.
REQ-007 sdr_rdy  output  1  one-cycle response strobe.
REQ-008 inv  input  1  one-cycle cache-invalidate strobe.
REQ-009 mem_addr  output  24 [24:1]  halfword address to the memory port.
REQ-010 mem_rd  output  1  read request level; held until mem_ack.
REQ-011 mem_ack  input  1  one-cycle completion for the current mem_addr.
REQ-012 mem_dout  input  16  read data; valid when mem_ack=1.

Function
REQ-013 Line: 4 halfwords (64 bits); tag = addr[24:3]; one valid bit.
REQ-014 States: IDLE, FILL, RESP.
REQ-015 IDLE + sdr_req, hit (CACHE_EN=1, valid, tag match): transition to RESP; sdr_rdy=1 on the next cycle (latency 1).
REQ-016 IDLE + sdr_req, miss: latch tag and dword index addr[2]; enter FILL; assert mem_rd with mem_addr={tag,2'b00} on the next cycle.
REQ-017 FILL, on each mem_ack:
  - store mem_dout into halfword k; k counts 0..3;
  - after k=0..2, mem_addr advances to {tag,k+1} in the next cycle and mem_rd stays high;
  - after k=3, mem_rd goes low in the next cycle; set valid=1 and tag; go to RESP.
REQ-018 RESP lasts one cycle:
  - sdr_rdy=1;
  - sdr_data={hw[2i+1],hw[2i]}, where i=addr[2] (low halfword from the even address);
  - then go to IDLE, or serve the pending request.
REQ-019 sdr_req while not in IDLE is captured in a one-deep pending register (address included).
  - The pending request is served as an IDLE request in the cycle after RESP.
  - A further request while one is already pending overwrites it (last wins).
REQ-020 inv clears valid in the next cycle.
  - inv during FILL: the fill completes and the response is delivered, but valid ends at 0.
  - inv coinciding with a hit lookup: the hit is still served.
REQ-021 mem_ack outside FILL is ignored.
REQ-022 Miss latency:
  - sdr_rdy comes 1 cycle after the 4th mem_ack;
  - minimum total is 6 cycles from sdr_req, with zero-wait acks.
REQ-023 Address arithmetic does not wrap; tag 22'h3FFFFF fills halfwords 24'hFFFFFC..24'hFFFFFF.

Reset
REQ-024 Reset forces asynchronously:
  - state=IDLE, valid=0, pending=0, k=0;
  - mem_rd=0, sdr_rdy=0, sdr_data=0, mem_addr=0.
REQ-025 Reset during FILL aborts the fill: no sdr_rdy is produced and the line stays invalid.
REQ-026 The first request after reset release is always a miss.

Structure
REQ-027 m72_pkg holds the line-size constants (LINE_HW=4, tag width 22).
REQ-028 The state enum is local to the module.
REQ-029 Line storage plus tag/valid is one sub-module: resp_line_buf.

Verification
REQ-030 Cold miss:
  - stimulus: after reset, sdr_req with addr 24'h000100; memory returns 1111,2222,3333,4444 with zero-wait acks;
  - response: mem_addr sequence 100,101,102,103; sdr_data=32'h22221111 exactly 6 cycles after sdr_req.
REQ-031 Hit:
  - stimulus: after REQ-030, sdr_req with addr 24'h000102;
  - response: sdr_rdy 1 cycle later with sdr_data=32'h44443333; mem_rd stays 0.
REQ-032 Pending request:
  - stimulus: sdr_req 24'h000200, then a second sdr_req 24'h000202 two cycles later, during FILL;
  - response: the second request is served as a hit; two sdr_rdy pulses, in order; no second fill.
REQ-033 Invalidate mid-fill:
  - stimulus: inv during the 2nd ack of a fill, then repeat the same address;
  - response: the first response is correct; the repeat triggers a new 4-read fill.
REQ-034 Reset mid-fill:
  - stimulus: reset asserted after the 2nd ack;
  - response: mem_rd=0 immediately; no sdr_rdy; the next request to the same address fills from halfword 0.
REQ-035 CACHE_EN=0:
  - stimulus: two identical requests;
  - response: both perform 4 memory reads.
